// File: rtl/jp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jp_ctrl
//  Purpose  : NES joypad controller. A free-running timer starts a poll of
//             both pads over the serial latch/clock protocol. Each poll fills
//             capture registers. The captures are then committed atomically
//             to the button registers pad1_q/pad2_q. The CPU reads the
//             committed buttons through the 0x4016/0x4017 strobe/shift
//             registers.
//  Ports    : clk_in       system clock
//             rst_in       synchronous active-high reset
//             ce_in        CPU bus-cycle commit pulse
//             a_in[15:0]   CPU address
//             r_nw_in      1 = read, 0 = write
//             d_in[7:0]    CPU write data (only bit 0 is used)
//             d_out[7:0]   CPU read data, 0 when not selected (OR-bus)
//             jp_data1_in  pad 1 serial data, active-low
//             jp_data2_in  pad 2 serial data, active-low
//             jp_clk       pad shift clock, registered, idle low
//             jp_latch     pad parallel-load latch, registered, idle low
//  Options  : JP_DEBOUNCE_EN - a capture commits only when it matches the
//             previous poll's capture.
//  Revision : 1.0 - initial release
// ============================================================================
module jp_ctrl #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned POLL_PERIOD = 833333
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ce_in,
  input  logic [15:0] a_in,
  input  logic        r_nw_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  input  logic        jp_data1_in,
  input  logic        jp_data2_in,
  output logic        jp_clk,
  output logic        jp_latch
);

  localparam int unsigned TMR_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  // The divider must hold the latch length minus one, which is 2*CLK_DIV-1.
  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      ADDR_JOY1  = 16'h4016;
  localparam logic [15:0]      ADDR_JOY2  = 16'h4017;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_SAMPLE = 3'd2,
    S_CLK_HI = 3'd3,
    S_CLK_LO = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       cap1_q, cap1_d, cap2_q, cap2_d;
  logic [7:0]       pad1_q, pad1_d, pad2_q, pad2_d;
  logic [7:0]       sr1_q, sr1_d, sr2_q, sr2_d;
  logic             strobe_q, strobe_d;
  logic             jp_clk_q, jp_clk_d;
  logic             jp_latch_q, jp_latch_d;
`ifdef JP_DEBOUNCE_EN
  logic [7:0]       prev1_q, prev1_d, prev2_q, prev2_d;
`endif

  logic poll_req;
  logic wr_joy1, rd_joy1, rd_joy2;
  logic unused_d_in;

  assign unused_d_in = ^d_in[7:1];

  // --------------------------------------------------------------------------
  // Poll timer and pad-protocol FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    cap1_d   = cap1_q;
    cap2_d   = cap2_q;
    pad1_d   = pad1_q;
    pad2_d   = pad2_q;
`ifdef JP_DEBOUNCE_EN
    prev1_d  = prev1_q;
    prev2_d  = prev2_q;
`endif

    poll_req = (timer_q == TMR_LAST);
    timer_d  = poll_req ? '0 : timer_q + TMR_W'(1);

    case (state_q)
      S_IDLE: begin
        // A request arriving mid-poll is dropped; the timer keeps running.
        if (poll_req) begin
          state_d = S_LATCH;
          div_d   = '0;
        end
      end
      S_LATCH: begin
        if (div_q == LATCH_LAST) begin
          state_d = S_SAMPLE;
          idx_d   = '0;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_SAMPLE: begin
        // Pads drive low for a pressed button; store 1 = pressed.
        cap1_d[idx_q] = ~jp_data1_in;
        cap2_d[idx_q] = ~jp_data2_in;
        if (idx_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CLK_HI;
          div_d   = '0;
        end
      end
      S_CLK_HI: begin
        if (div_q == HALF_LAST) begin
          state_d = S_CLK_LO;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_CLK_LO: begin
        if (div_q == HALF_LAST) begin
          state_d = S_SAMPLE;
          idx_d   = idx_q + 3'd1;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
`ifdef JP_DEBOUNCE_EN
        // Commit only captures seen identically on two consecutive polls.
        if (cap1_q == prev1_q) pad1_d = cap1_q;
        if (cap2_q == prev2_q) pad2_d = cap2_q;
        prev1_d = cap1_q;
        prev2_d = cap2_q;
`else
        pad1_d = cap1_q;
        pad2_d = cap2_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pad pins follow the state being entered, so they are glitch-free flops
    // and can never be high together.
    jp_latch_d = (state_d == S_LATCH);
    jp_clk_d   = (state_d == S_CLK_HI);
  end

  // --------------------------------------------------------------------------
  // CPU strobe / shift registers
  // --------------------------------------------------------------------------
  assign wr_joy1 = ce_in && !r_nw_in && (a_in == ADDR_JOY1);
  assign rd_joy1 = ce_in &&  r_nw_in && (a_in == ADDR_JOY1);
  assign rd_joy2 = ce_in &&  r_nw_in && (a_in == ADDR_JOY2);

  always_comb begin
    strobe_d = strobe_q;
    sr1_d    = sr1_q;
    sr2_d    = sr2_q;

    // pad*_q here is the pre-commit value when S_DONE commits in this cycle.
    if (strobe_q) begin
      sr1_d = pad1_q;
      sr2_d = pad2_q;
    end

    if (wr_joy1) begin
      strobe_d = d_in[0];
      sr1_d    = pad1_q;
      sr2_d    = pad2_q;
    end else if (!strobe_q) begin
      // Ones shift in from the top so reads past the eighth return 1.
      if (rd_joy1) sr1_d = {1'b1, sr1_q[7:1]};
      if (rd_joy2) sr2_d = {1'b1, sr2_q[7:1]};
    end
  end

  always_comb begin
    d_out = 8'h00;
    if (r_nw_in && (a_in == ADDR_JOY1)) d_out = {7'b0, sr1_q[0]};
    if (r_nw_in && (a_in == ADDR_JOY2)) d_out = {7'b0, sr2_q[0]};
  end

  assign jp_clk   = jp_clk_q;
  assign jp_latch = jp_latch_q;

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      cap1_q     <= '0;
      cap2_q     <= '0;
      pad1_q     <= '0;
      pad2_q     <= '0;
      sr1_q      <= '0;
      sr2_q      <= '0;
      strobe_q   <= 1'b0;
      jp_clk_q   <= 1'b0;
      jp_latch_q <= 1'b0;
`ifdef JP_DEBOUNCE_EN
      prev1_q    <= '0;
      prev2_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      cap1_q     <= cap1_d;
      cap2_q     <= cap2_d;
      pad1_q     <= pad1_d;
      pad2_q     <= pad2_d;
      sr1_q      <= sr1_d;
      sr2_q      <= sr2_d;
      strobe_q   <= strobe_d;
      jp_clk_q   <= jp_clk_d;
      jp_latch_q <= jp_latch_d;
`ifdef JP_DEBOUNCE_EN
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jp_ctrl
//  Purpose  : Self-checking bench for jp_ctrl with a behavioural pad model.
//             Expected values are queued when stimulus is applied and are
//             popped when the DUT answers. Expectations follow JP_DEBOUNCE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jp_ctrl;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned POLL_PERIOD = 100;
  localparam logic [15:0] JOY1        = 16'h4016;
  localparam logic [15:0] JOY2        = 16'h4017;

  logic        clk_in  = 1'b0;
  logic        rst_in  = 1'b1;
  logic        ce_in   = 1'b0;
  logic [15:0] a_in    = 16'h0000;
  logic        r_nw_in = 1'b1;
  logic [7:0]  d_in    = 8'h00;
  logic [7:0]  d_out;
  logic        jp_data1_in;
  logic        jp_data2_in;
  logic        jp_clk;
  logic        jp_latch;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] exp_q[$];

  jp_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ce_in      (ce_in),
    .a_in       (a_in),
    .r_nw_in    (r_nw_in),
    .d_in       (d_in),
    .d_out      (d_out),
    .jp_data1_in(jp_data1_in),
    .jp_data2_in(jp_data2_in),
    .jp_clk     (jp_clk),
    .jp_latch   (jp_latch)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Pad model: 4021-style shift register; latch loads the active-low
  // buttons, each rising jp_clk shifts the next button onto the data pin.
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] sh1 = 8'hFF, sh2 = 8'hFF;
  logic       clk_prev = 1'b0;

  always @(posedge clk_in) begin
    clk_prev <= jp_clk;
    if (jp_latch) begin
      sh1 <= ~btn1;
      sh2 <= ~btn2;
    end else if (jp_clk && !clk_prev) begin
      sh1 <= {1'b1, sh1[7:1]};
      sh2 <= {1'b1, sh2[7:1]};
    end
  end

  assign jp_data1_in = sh1[0];
  assign jp_data2_in = sh2[0];

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a_in = addr; r_nw_in = 1'b0; d_in = data; ce_in = 1'b1;
    tick();
    ce_in = 1'b0; r_nw_in = 1'b1; a_in = 16'h0000; d_in = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [7:0] v);
    a_in = addr; r_nw_in = 1'b1; ce_in = 1'b1;
    #2 v = d_out;
    tick();
    ce_in = 1'b0; a_in = 16'h0000;
  endtask

  task automatic read_pad(input logic [15:0] addr, output logic [7:0] v);
    logic [7:0] rd;
    bus_write(JOY1, 8'h01);
    bus_write(JOY1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      bus_read(addr, rd);
      v[i] = rd[0];
    end
  endtask

  task automatic wait_poll();
    bit   seen;
    logic prev;
    seen = 1'b0;
    prev = jp_latch;
    for (int i = 0; i < 250 && !seen; i++) begin
      tick();
      if (jp_latch && !prev) seen = 1'b1;
      prev = jp_latch;
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL poll_start: latch rise seen=%0b required=1", seen);
    else n_pass++;
    repeat (45) tick();
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_in = 1'b1;
    a_in = JOY1; r_nw_in = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (jp_clk !== 1'b0) $display("FAIL reset_jp_clk: got %0b required 0", jp_clk);
    else n_pass++;
    n_checks++;
    if (jp_latch !== 1'b0) $display("FAIL reset_jp_latch: got %0b required 0", jp_latch);
    else n_pass++;
    n_checks++;
    if (d_out !== 8'h00) $display("FAIL reset_d_out_4016: got %h required 00", d_out);
    else n_pass++;
    a_in = JOY2;
    #1;
    n_checks++;
    if (d_out !== 8'h00) $display("FAIL reset_d_out_4017: got %h required 00", d_out);
    else n_pass++;
    a_in = 16'h0000;
  endtask

  task automatic test_poll_waveform();
    logic [7:0] e, got;
    logic       l_e, c_e;
    rst_in = 1'b0;
    for (int k = 1; k <= 145; k++) begin
      l_e = (k >= 100) && (k <= 103);
      c_e = (k >= 105) && (k <= 139) && (((k - 105) % 5) < 2);
      exp_q.push_back({6'b0, l_e, c_e});
      tick();
      e   = exp_q.pop_front();
      got = {6'b0, jp_latch, jp_clk};
      n_checks++;
      if (got !== e)
        $display("FAIL pins_cycle_%0d: latch/clk got %b%b required %b%b", k, got[1], got[0], e[1], e[0]);
      else n_pass++;
    end
  endtask

  task automatic test_poll_data();
    logic [7:0] v, e;
    exp_q.push_back(8'h81);
    read_pad(JOY1, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL pad1_commit: got %h required %h", v, e);
    else n_pass++;
    exp_q.push_back(8'h00);
    read_pad(JOY2, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL pad2_commit: got %h required %h", v, e);
    else n_pass++;
  endtask

  task automatic test_shift_sequence();
    logic [7:0] pad, v, e;
    pad = 8'h81;
    bus_write(JOY1, 8'h01);
    bus_write(JOY1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({7'b0, (i < 8) ? pad[i] : 1'b1});
      bus_read(JOY1, v);
      e = exp_q.pop_front();
      n_checks++;
      if (v !== e) $display("FAIL shift_read_%0d: got %h required %h", i, v, e);
      else n_pass++;
    end
  endtask

  task automatic test_strobe();
    logic [7:0] v, e;
    btn2 = 8'h01;
    wait_poll();
    bus_write(JOY1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h01);
      bus_read(JOY2, v);
      e = exp_q.pop_front();
      n_checks++;
      if (v !== e) $display("FAIL strobe_read_%0d: got %h required %h", i, v, e);
      else n_pass++;
    end
    a_in = 16'h0000; r_nw_in = 1'b1;
    #2;
    n_checks++;
    if (d_out !== 8'h00) $display("FAIL idle_bus: got %h required 00", d_out);
    else n_pass++;
    tick();
    bus_write(JOY1, 8'h00);
    exp_q.push_back(8'h01);
    bus_read(JOY2, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL unstrobe_read0: got %h required %h", v, e);
    else n_pass++;
    // A write to 0x4017 must neither set the strobe nor reload.
    bus_write(JOY2, 8'h01);
    exp_q.push_back(8'h00);
    bus_read(JOY2, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL write_4017_ignored: got %h required %h", v, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_poll();
    bit         seen, hit;
    int         pulses, r0;
    logic       prev;
    logic [7:0] v, e;
    btn1 = 8'hFF; btn2 = 8'hFF;
    seen = 1'b0; hit = 1'b0; pulses = 0;
    prev = jp_latch;
    for (int i = 0; i < 250 && !seen; i++) begin
      tick();
      if (jp_latch && !prev) seen = 1'b1;
      prev = jp_latch;
    end
    prev = jp_clk;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (jp_clk && !prev) begin
        pulses++;
        if (pulses == 4) hit = 1'b1;
      end
      prev = jp_clk;
    end
    n_checks++;
    if (hit !== 1'b1) $display("FAIL midpoll_reach_idx3: reached=%0b required=1", hit);
    else n_pass++;
    rst_in = 1'b1;
    tick();
    n_checks++;
    if ({jp_latch, jp_clk} !== 2'b00) $display("FAIL midpoll_pins: latch/clk got %b%b required 00", jp_latch, jp_clk);
    else n_pass++;
    r0 = cyc;
    rst_in = 1'b0;
    exp_q.push_back(8'h00);
    read_pad(JOY1, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL midpoll_pad1: got %h required %h", v, e);
    else n_pass++;
    exp_q.push_back(8'h00);
    read_pad(JOY2, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL midpoll_pad2: got %h required %h", v, e);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (jp_latch) seen = 1'b1;
      else tick();
    end
    n_checks++;
    if ((cyc - r0) != 100) $display("FAIL restart_delay: got %0d required 100", cyc - r0);
    else n_pass++;
    repeat (45) tick();
`ifdef JP_DEBOUNCE_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'hFF);
`endif
    read_pad(JOY1, v);
    e = exp_q.pop_front();
    n_checks++;
    if (v !== e) $display("FAIL post_reset_poll: got %h required %h", v, e);
    else n_pass++;
  endtask

  task automatic test_debounce();
    logic [7:0] seq_btn [5];
    logic [7:0] seq_exp [5];
    logic [7:0] v, e;
    seq_btn = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
`ifdef JP_DEBOUNCE_EN
    seq_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
`else
    seq_exp = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01};
`endif
    for (int i = 0; i < 5; i++) begin
      btn1 = seq_btn[i];
      exp_q.push_back(seq_exp[i]);
      wait_poll();
      read_pad(JOY1, v);
      e = exp_q.pop_front();
      n_checks++;
      if (v !== e) $display("FAIL debounce_poll_%0d: got %h required %h", i, v, e);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    btn1 = 8'h81;
    btn2 = 8'h00;
    test_reset();
    test_poll_waveform();
    test_poll_data();
    test_shift_sequence();
    test_strobe();
    test_reset_mid_poll();
    test_debounce();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
